// File: rtl/fpnew_fma_out_buf.sv
// rtl/fpnew_fma_out_buf.sv - FMA result output buffer: NaN canonicalisation, NaN-boxing, 2-deep FIFO, sticky flags
module fpnew_fma_out_buf #(
    parameter logic [2:0] FpFormat = 3'd0,
    parameter int         Flen     = 64,
    parameter bit         CanonNaN = 1'b1,
    localparam int EXP_BITS = (FpFormat == 3'd1) ? 11 :
                              ((FpFormat == 3'd2) || (FpFormat == 3'd4)) ? 5 : 8,
    localparam int MAN_BITS = (FpFormat == 3'd0) ? 23 :
                              (FpFormat == 3'd1) ? 52 :
                              (FpFormat == 3'd2) ? 10 :
                              (FpFormat == 3'd3) ? 7  : 2,
    localparam int WIDTH    = 1 + EXP_BITS + MAN_BITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_result_i,
    input  logic [4:0]       in_status_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Flen-1:0]  out_result_o,
    output logic [4:0]       out_status_o,
    input  logic             fflags_clr_i,
    output logic [4:0]       fflags_o,
    output logic [15:0]      nan_count_o
);

    // Entry layout: {nan, status[4:0], value[WIDTH-1:0]}
    localparam int ENTRY_W = WIDTH + 6;
    localparam logic [MAN_BITS-1:0] QNAN_MAN = MAN_BITS'(1) << (MAN_BITS - 1);
    localparam logic [WIDTH-1:0]    QNAN     = {1'b0, {EXP_BITS{1'b1}}, QNAN_MAN};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ENTRY_W-1:0]   mem [2];
    logic [ENTRY_W-1:0]   mem_next [2];
    logic                 head;
    logic                 tail;
    logic                 head_next;
    logic                 push;
    logic                 pop;
    logic                 in_nan;
    logic [WIDTH-1:0]     in_value;
    logic [ENTRY_W-1:0]   in_entry;
    logic [ENTRY_W-1:0]   out_entry_next;
    logic [Flen-1:0]      boxed_next;
    logic                 head_nan;
    logic [4:0]           head_status;

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    // NaN classification and optional canonicalisation of the incoming result
    always_comb begin
        in_nan   = (in_result_i[WIDTH-2:MAN_BITS] == {EXP_BITS{1'b1}}) &&
                   (in_result_i[MAN_BITS-1:0] != '0);
        in_value = (CanonNaN && in_nan) ? QNAN : in_result_i;
        in_entry = {in_nan, in_status_i, in_value};
    end

    // Occupancy state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Occupancy next-state logic
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = FULL;
                else if (pop && !push) state_next = EMPTY;
            end
            FULL:  if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Storage write and the entry that will sit at the head after this edge
    always_comb begin
        mem_next[0] = mem[0];
        mem_next[1] = mem[1];
        if (push) mem_next[tail] = in_entry;
        head_next      = head ^ pop;
        out_entry_next = mem_next[head_next];
        head_nan       = mem[head][ENTRY_W-1];
        head_status    = mem[head][WIDTH+4:WIDTH];
    end

    // NaN-boxing into the register-file container; no padding when widths match
    generate
        if (Flen > WIDTH) begin : g_box
            assign boxed_next = {{(Flen - WIDTH){1'b1}}, out_entry_next[WIDTH-1:0]};
        end else begin : g_nobox
            assign boxed_next = out_entry_next[WIDTH-1:0];
        end
    endgenerate

    // Datapath: pointers, storage, registered outputs, sticky flags and NaN counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem[0]       <= '0;
            mem[1]       <= '0;
            head         <= 1'b0;
            tail         <= 1'b0;
            out_valid_o  <= 1'b0;
            in_ready_o   <= 1'b1;
            out_result_o <= '0;
            out_status_o <= '0;
            fflags_o     <= '0;
            nan_count_o  <= '0;
        end else begin
            mem[0]      <= mem_next[0];
            mem[1]      <= mem_next[1];
            head        <= head_next;
            tail        <= tail ^ push;
            out_valid_o <= (state_next != EMPTY);
            in_ready_o  <= (state_next != FULL);
            if (state_next != EMPTY) begin
                out_result_o <= boxed_next;
                out_status_o <= out_entry_next[WIDTH+4:WIDTH];
            end
            if (pop) begin
                fflags_o <= (fflags_clr_i ? 5'd0 : fflags_o) | head_status;
                if (head_nan && (nan_count_o != 16'hFFFF)) begin
                    nan_count_o <= nan_count_o + 16'd1;
                end
            end else if (fflags_clr_i) begin
                fflags_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fpnew_fma_out_buf.sv
// tb/tb_fpnew_fma_out_buf.sv - directed self-checking bench for fpnew_fma_out_buf
module tb_fpnew_fma_out_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in32;
    logic [63:0] in64;
    logic [4:0]  status;
    logic        fflags_clr;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
    logic [63:0] a_out_result, b_out_result, c_out_result;
    logic [4:0]  a_out_status, b_out_status, c_out_status;
    logic [4:0]  a_fflags, b_fflags, c_fflags;
    logic [15:0] a_nan, b_nan, c_nan;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fpnew_fma_out_buf #(.FpFormat(3'd0), .Flen(64), .CanonNaN(1'b1)) u_a (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
        .in_result_i(in32), .in_status_i(status), .out_valid_o(a_out_valid),
        .out_ready_i(out_ready), .out_result_o(a_out_result), .out_status_o(a_out_status),
        .fflags_clr_i(fflags_clr), .fflags_o(a_fflags), .nan_count_o(a_nan)
    );

    fpnew_fma_out_buf #(.FpFormat(3'd0), .Flen(64), .CanonNaN(1'b0)) u_b (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
        .in_result_i(in32), .in_status_i(status), .out_valid_o(b_out_valid),
        .out_ready_i(out_ready), .out_result_o(b_out_result), .out_status_o(b_out_status),
        .fflags_clr_i(fflags_clr), .fflags_o(b_fflags), .nan_count_o(b_nan)
    );

    fpnew_fma_out_buf #(.FpFormat(3'd1), .Flen(64), .CanonNaN(1'b1)) u_c (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(c_in_ready),
        .in_result_i(in64), .in_status_i(status), .out_valid_o(c_out_valid),
        .out_ready_i(out_ready), .out_result_o(c_out_result), .out_status_o(c_out_status),
        .fflags_clr_i(fflags_clr), .fflags_o(c_fflags), .nan_count_o(c_nan)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in32 = '0; in64 = '0;
        status = '0; fflags_clr = 1'b0;
        step();
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_result", a_out_result, 0);
        chk("rst_out_status", a_out_status, 0);
        chk("rst_fflags", a_fflags, 0);
        chk("rst_nan_count", a_nan, 0);
        rst = 1'b0;

        // NaN canonicalisation / boxing
        in_valid = 1'b1; out_ready = 1'b1; in32 = 32'h7FC0_1234;
        in64 = 64'h7FF0_0000_0000_0001; status = 5'b10000;
        step();
        in_valid = 1'b0;
        chk("nan32_canon", a_out_result, 64'hFFFFFFFF_7FC00000);
        chk("nan32_status", a_out_status, 5'b10000);
        chk("nan32_valid", a_out_valid, 1);
        chk("nan32_raw", b_out_result, 64'hFFFFFFFF_7FC01234);
        chk("nan64_canon", c_out_result, 64'h7FF8_0000_0000_0000);
        step();
        chk("nan32_fflags", a_fflags, 5'b10000);
        chk("nan32_count", a_nan, 1);
        chk("nan32_empty", a_out_valid, 0);
        chk("nan64_count", c_nan, 1);

        // Ordinary values and infinity
        in_valid = 1'b1; in32 = 32'h3F80_0000; in64 = 64'h7FF0_0000_0000_0000; status = 5'b00000;
        step();
        in_valid = 1'b0;
        chk("one32", a_out_result, 64'hFFFFFFFF_3F800000);
        chk("inf64", c_out_result, 64'h7FF0_0000_0000_0000);
        step();
        chk("one32_count", a_nan, 1);
        chk("inf64_count", c_nan, 1);

        // Negative signalling-style NaN, kept raw when canonicalisation is off
        in_valid = 1'b1; in32 = 32'hFF80_0001;
        step();
        in_valid = 1'b0;
        chk("snan32_raw", b_out_result, 64'hFFFFFFFF_FF800001);
        chk("snan32_canon", a_out_result, 64'hFFFFFFFF_7FC00000);
        step();
        chk("snan32_count_a", a_nan, 2);
        chk("snan32_count_b", b_nan, 2);

        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        chk("clr_no_pop", a_fflags, 0);

        // Backpressure: A, B fill the buffer, C waits upstream
        out_ready = 1'b0; in_valid = 1'b1; in32 = 32'h1111_1111; status = 5'b00001;
        step();
        chk("bp_ready_one", a_in_ready, 1);
        in32 = 32'h2222_2222; status = 5'b00100;
        step();
        chk("bp_ready_full", a_in_ready, 0);
        chk("bp_head_a", a_out_result, 64'hFFFFFFFF_11111111);
        in32 = 32'h3333_3333; status = 5'b01000;
        step();
        chk("bp_hold_ready", a_in_ready, 0);
        chk("bp_hold_a", a_out_result, 64'hFFFFFFFF_11111111);
        chk("bp_hold_status", a_out_status, 5'b00001);
        out_ready = 1'b1;
        step();
        chk("bp_head_b", a_out_result, 64'hFFFFFFFF_22222222);
        chk("bp_ready_back", a_in_ready, 1);
        chk("bp_fflags_a", a_fflags, 5'b00001);
        step();
        in_valid = 1'b0;
        chk("bp_head_c", a_out_result, 64'hFFFFFFFF_33333333);
        chk("bp_fflags_ab", a_fflags, 5'b00101);
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        chk("clr_with_pop", a_fflags, 5'b01000);
        chk("bp_drained", a_out_valid, 0);
        chk("bp_count", a_nan, 2);

        // Reset while full
        out_ready = 1'b0; in_valid = 1'b1; in32 = 32'h7FC0_0000; status = 5'b00000;
        step();
        step();
        chk("full_before_rst", a_in_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_full_valid", a_out_valid, 0);
        chk("rst_full_ready", a_in_ready, 1);
        chk("rst_full_count", a_nan, 0);
        chk("rst_full_fflags", a_fflags, 0);

        // Saturation of the NaN counter at full throughput
        out_ready = 1'b1; in_valid = 1'b1;
        repeat (65535) step();
        chk("sat_fffe", a_nan, 16'hFFFE);
        step();
        chk("sat_ffff", a_nan, 16'hFFFF);
        repeat (4) step();
        chk("sat_hold", a_nan, 16'hFFFF);
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
